// File: rtl/demux_1to4_reg_pkg.sv
// -----------------------------------------------------------------------------
// demux_1to4_reg_pkg
// Shared constants and types for the registered 1-to-4 demultiplexer.
//   NUM_LANES : number of output lanes
//   SEL_W     : width of the lane select code
//   sel_t     : lane select code type
// -----------------------------------------------------------------------------
package demux_1to4_reg_pkg;

   localparam int NUM_LANES = 4;
   localparam int SEL_W     = 2;

   typedef logic [SEL_W-1:0] sel_t;

endpackage : demux_1to4_reg_pkg

// File: rtl/demux_1to4_reg_if.sv
// -----------------------------------------------------------------------------
// demux_1to4_reg_if
// Bus between a data source and the demultiplexer.
//   in     : data to be steered (DATA_W bits)
//   select : lane select code
//   out    : registered lane outputs, lane k = out[k*DATA_W +: DATA_W]
// Modports:
//   master : drives in/select, observes out (the source side)
//   slave  : observes in/select, drives out (the demultiplexer)
// There is no handshake: the source presents in/select every cycle and the
// demultiplexer samples them on every rising clock edge.
// -----------------------------------------------------------------------------
interface demux_1to4_reg_if
   import demux_1to4_reg_pkg::*;
#(
   parameter int DATA_W = 1
);

   logic [DATA_W-1:0]           in;
   sel_t                        select;
   logic [NUM_LANES*DATA_W-1:0] out;

   modport master (
      output in,
      output select,
      input  out
   );

   modport slave (
      input  in,
      input  select,
      output out
   );

endinterface : demux_1to4_reg_if

// File: rtl/demux_1to4_reg_decode.sv
// -----------------------------------------------------------------------------
// demux_decode_2to4
// Combinational 2-bit to one-hot lane decoder.
//   i_sel    : lane select code
//   o_onehot : one-hot lane enable; all zero for any code that is not one of
//              the four defined values (X/Z in simulation)
// -----------------------------------------------------------------------------
module demux_decode_2to4
   import demux_1to4_reg_pkg::*;
(
   input  sel_t                 i_sel,
   output logic [NUM_LANES-1:0] o_onehot
);

   // Exact-match case: an X or Z bit in i_sel matches none of the items and
   // falls through to the default, so the enable vector never goes X.
   always_comb begin
      o_onehot = '0;
      case (i_sel)
         2'b00:   o_onehot = 4'b0001;
         2'b01:   o_onehot = 4'b0010;
         2'b10:   o_onehot = 4'b0100;
         2'b11:   o_onehot = 4'b1000;
         default: o_onehot = '0;
      endcase
   end

endmodule : demux_decode_2to4

// File: rtl/demux_1to4_reg.sv
// -----------------------------------------------------------------------------
// demux_1to4_reg
// Registered 1-to-4 demultiplexer. The input word is steered to the lane
// chosen by select; the other three lanes are driven to zero. One cycle of
// latency, no combinational path from inputs to out.
//   clock : rising-edge clock
//   reset : synchronous, active-high reset; clears out
//   bus   : demux_1to4_reg_if slave (in, select -> out)
// -----------------------------------------------------------------------------
module demux_1to4_reg
   import demux_1to4_reg_pkg::*;
#(
   parameter int DATA_W = 1
)(
   input  logic             clock,
   input  logic             reset,
   demux_1to4_reg_if.slave  bus
);

   logic [NUM_LANES-1:0]        w_onehot;
   logic [NUM_LANES*DATA_W-1:0] w_next;

   demux_decode_2to4 u_decode (
      .i_sel    (bus.select),
      .o_onehot (w_onehot)
   );

   // Gate the input into each lane by its enable. Unselected lanes become 0
   // even if in carries X, so an unknown input only reaches the chosen lane.
   always_comb begin
      w_next = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         w_next[k*DATA_W +: DATA_W] = {DATA_W{w_onehot[k]}} & bus.in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.out <= '0;
      end else begin
         bus.out <= w_next;
      end
   end

endmodule : demux_1to4_reg

// File: tb/tb_demux_1to4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_reg
// Bench for demux_1to4_reg with DATA_W=1 and DATA_W=8 instances sharing one
// clock and reset.
// -----------------------------------------------------------------------------
module tb_demux_1to4_reg;
   import demux_1to4_reg_pkg::*;

   // ---------------------------------------------------------------- clock/reset
   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- DUTs
   demux_1to4_reg_if #(.DATA_W(1)) bus1 ();
   demux_1to4_reg_if #(.DATA_W(8)) bus8 ();

   demux_1to4_reg #(.DATA_W(1)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1.slave)
   );

   demux_1to4_reg #(.DATA_W(8)) dut8 (
      .clock (clock),
      .reset (reset),
      .bus   (bus8.slave)
   );

   // ---------------------------------------------------------------- scoreboard
   logic [3:0]  exp_q[$];
   logic [31:0] exp8_q[$];
   int total = 0;
   int bad   = 0;

   // Reference behaviour, evaluated on the stimulus actually applied.
   function automatic logic [3:0] model1(logic r, logic d, logic [1:0] s);
      logic [3:0] m;
      m = '0;
      if (r !== 1'b1 && !$isunknown(s)) m[s] = d;
      return m;
   endfunction

   function automatic logic [31:0] model8(logic r, logic [7:0] d, logic [1:0] s);
      logic [31:0] m;
      m = '0;
      if (r !== 1'b1 && !$isunknown(s)) m[s*8 +: 8] = d;
      return m;
   endfunction

   // ---------------------------------------------------------------- driver
   // Apply inputs away from the edge, push the expected result, then after the
   // next rising edge pop and compare both lanes-vectors.
   task automatic step(input string name, input logic r,
                       input logic d1, input logic [1:0] s1,
                       input logic [7:0] d8, input logic [1:0] s8);
      logic [3:0]  e1;
      logic [31:0] e8;
      @(negedge clock);
      reset       = r;
      bus1.in     = d1;
      bus1.select = s1;
      bus8.in     = d8;
      bus8.select = s8;
      #1;
      exp_q.push_back(model1(reset, bus1.in, bus1.select));
      exp8_q.push_back(model8(reset, bus8.in, bus8.select));
      @(posedge clock);
      #1;
      e1 = exp_q.pop_front();
      e8 = exp8_q.pop_front();
      total++;
      if (bus1.out !== e1) begin
         bad++;
         $display("FAIL %s w1 got=%b exp=%b", name, bus1.out, e1);
      end
      total++;
      if (bus8.out !== e8) begin
         bad++;
         $display("FAIL %s w8 got=%h exp=%h", name, bus8.out, e8);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_powerup;
      // No reset and select never driven: first edge must give zero.
      reset = 1'b0;
      @(posedge clock);
      #1;
      total++;
      if (bus1.out !== 4'b0000) begin
         bad++;
         $display("FAIL powerup got=%b exp=0000", bus1.out);
      end
   endtask

   task automatic test_reset;
      step("reset_a", 1'b1, 1'b1, 2'b10, 8'hA5, 2'b10);
      total++;
      if (bus1.out !== 4'b0000) begin
         bad++;
         $display("FAIL reset_hold got=%b exp=0000", bus1.out);
      end
      step("reset_b", 1'b1, 1'b1, 2'b10, 8'hA5, 2'b10);
      step("reset_rel", 1'b0, 1'b1, 2'b10, 8'hA5, 2'b10);
      total++;
      if (bus1.out !== 4'b0100) begin
         bad++;
         $display("FAIL reset_release got=%b exp=0100", bus1.out);
      end
   endtask

   task automatic test_valid_sweep;
      logic [3:0] lit;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 5; c++) begin
            step("valid", 1'b0, 1'b1, 2'(s), 8'(8'h11 * (s + 1)), 2'(s));
         end
         lit = 4'b0001 << s;
         total++;
         if (bus1.out !== lit) begin
            bad++;
            $display("FAIL valid_const sel=%0d got=%b exp=%b", s, bus1.out, lit);
         end
      end
   endtask

   task automatic test_invalid_sweep;
      logic [1:0] codes [12];
      codes = '{2'bx0, 2'bx1, 2'b0x, 2'b1x, 2'bxx, 2'bxz,
                2'bzx, 2'bz0, 2'bz1, 2'b0z, 2'b1z, 2'bzz};
      for (int i = 0; i < 12; i++) begin
         for (int c = 0; c < 5; c++) begin
            step("invalid", 1'b0, 1'b1, codes[i], 8'hFF, codes[i]);
            total++;
            if ($isunknown(bus1.out) || $isunknown(bus8.out)) begin
               bad++;
               $display("FAIL invalid_x code=%0d got=%b exp=known", i, bus1.out);
            end
         end
      end
   endtask

   task automatic test_data_gating;
      step("gate_1", 1'b0, 1'b1, 2'b01, 8'h3C, 2'b01);
      step("gate_0", 1'b0, 1'b0, 2'b01, 8'h00, 2'b01);
      step("gate_1b", 1'b0, 1'b1, 2'b01, 8'hC3, 2'b01);
      total++;
      if (bus1.out !== 4'b0010) begin
         bad++;
         $display("FAIL gate_const got=%b exp=0010", bus1.out);
      end
   endtask

   task automatic test_mid_reset;
      step("mid_pre", 1'b0, 1'b1, 2'b11, 8'h5A, 2'b11);
      step("mid_pre2", 1'b0, 1'b1, 2'b11, 8'h5A, 2'b11);
      step("mid_rst", 1'b1, 1'b1, 2'b11, 8'h5A, 2'b11);
      step("mid_post", 1'b0, 1'b1, 2'b11, 8'h5A, 2'b11);
      total++;
      if (bus1.out !== 4'b1000) begin
         bad++;
         $display("FAIL mid_const got=%b exp=1000", bus1.out);
      end
   endtask

   task automatic test_wide;
      step("wide_a5", 1'b0, 1'b0, 2'b00, 8'hA5, 2'b10);
      total++;
      if (bus8.out !== 32'h00A5_0000) begin
         bad++;
         $display("FAIL wide_const got=%h exp=00a50000", bus8.out);
      end
      step("wide_zz", 1'b0, 1'b0, 2'b00, 8'hA5, 2'bzz);
      total++;
      if ($isunknown(bus8.out)) begin
         bad++;
         $display("FAIL wide_zz_x got=%h exp=known", bus8.out);
      end
   endtask

   task automatic test_back_to_back;
      logic [1:0] s;
      logic       d;
      logic [7:0] d8;
      for (int i = 0; i < 40; i++) begin
         s  = 2'($urandom_range(0, 3));
         d  = 1'($urandom_range(0, 1));
         d8 = 8'($urandom_range(0, 255));
         step("b2b", 1'($urandom_range(0, 9) == 0), d, s, d8, 2'($urandom_range(0, 3)));
      end
   endtask

   // ---------------------------------------------------------------- sequence
   initial begin
      test_powerup();
      test_reset();
      test_valid_sweep();
      test_invalid_sweep();
      test_data_gating();
      test_mid_reset();
      test_wide();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_demux_1to4_reg
